imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 13 +
 rtl/imem_loader_word_assembler.sv | 44 ++++
 rtl/imem_loader.sv | 104 ++++++++++
 tb/tb_imem_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] BREAK_WORD     = 32'h0000000d;
    localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian bytes into 32-bit words; flushes a zero-padded word on last.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        accept,
    input  logic        last,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        partial
);

    localparam logic [1:0] TOP_LANE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  lane;
    logic [23:0] acc;

    // Upper lanes of acc are always zero, so the current byte merges in directly.
    always_comb begin
        word = {8'h00, acc};
        word[{lane, 3'b000} +: 8] = data;
    end

    assign word_valid = accept & ((lane == TOP_LANE) | last);
    assign partial    = accept & last & (lane != TOP_LANE);

    always_ff @(posedge clock) begin
        if (clear) begin
            lane <= 2'd0;
            acc  <= 24'h0;
        end else if (accept) begin
            if (word_valid) begin
                lane <= 2'd0;
                acc  <= 24'h0;
            end else begin
                acc[{lane, 3'b000} +: 8] <= data;
                lane <= lane + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a program from a byte stream into instruction RAM, then releases the core.
// Optional: define IMEM_LOADER_CHECKSUM_EN to build an XOR checksum of written words.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_BITS  = 8,
    parameter int RESET_HOLD = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_byte,
    input  logic                 in_last,
    input  logic [ADDR_BITS-1:0] fetch_addr,
    output logic [31:0]          fetch_data,
    output logic                 core_reset,
    input  logic                 core_halted,
    output logic [ADDR_BITS:0]   loaded_words,
    output logic [1:0]           state,
    output logic                 error,
    output logic [31:0]          checksum
);

    localparam int                 DEPTH   = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [3:0]         HOLD_W  = 4'(RESET_HOLD);

    state_t      st, st_nxt;
    logic [3:0]  hold_cnt;
    logic [31:0] mem [DEPTH];

    logic        accept, full;
    logic [31:0] word;
    logic        word_valid, partial;

    assign full       = (loaded_words == DEPTH_W);
    assign accept     = in_valid & in_ready;
    assign in_ready   = (st == LOAD);
    assign core_reset = (st == LOAD) | ((st == RUN) & (hold_cnt < HOLD_W));
    assign state      = st;

    // Once RAM is full, bytes are still consumed (to reach in_last) but dropped.
    word_assembler u_asm (
        .clock      (clock),
        .clear      (reset),
        .accept     (accept & ~full),
        .last       (in_last),
        .data       (in_byte),
        .word       (word),
        .word_valid (word_valid),
        .partial    (partial)
    );

    always_ff @(posedge clock) begin
        if (reset) st <= LOAD;
        else       st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            LOAD:    if (accept & in_last) st_nxt = RUN;
            RUN:     if (core_halted & ~core_reset) st_nxt = DONE;
            DONE:    st_nxt = DONE;
            default: st_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            loaded_words <= '0;
            error        <= 1'b0;
            hold_cnt     <= 4'd0;
        end else begin
            if (word_valid)
                loaded_words <= loaded_words + 1'b1;
            if ((accept & full) | partial)
                error <= 1'b1;
            if ((st == RUN) && (hold_cnt < HOLD_W))
                hold_cnt <= hold_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (word_valid)
            mem[loaded_words[ADDR_BITS-1:0]] <= word;
    end

    // Fetches past the loaded image return a break so a runaway PC halts the core.
    assign fetch_data = ({1'b0, fetch_addr} < loaded_words) ? mem[fetch_addr] : BREAK_WORD;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum;
    always_ff @(posedge clock) begin
        if (reset)           csum <= 32'h0;
        else if (word_valid) csum <= csum ^ word;
    end
    assign checksum = csum;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a byte-count based reference model.
module tb_imem_loader;

    localparam int AB    = 8;
    localparam int DEPTH = 1 << AB;
    localparam int HOLD  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_byte = 8'h0;
    logic          in_last = 1'b0;
    logic [AB-1:0] fetch_addr = '0;
    logic [31:0]   fetch_data;
    logic          core_reset;
    logic          core_halted = 1'b0;
    logic [AB:0]   loaded_words;
    logic [1:0]    state;
    logic          error;
    logic [31:0]   checksum;

    imem_loader #(.ADDR_BITS(AB), .RESET_HOLD(HOLD)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .in_last(in_last), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .core_reset(core_reset), .core_halted(core_halted),
        .loaded_words(loaded_words), .state(state), .error(error), .checksum(checksum)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: everything derives from the count of bytes accepted this load.
    logic [31:0] m_mem [DEPTH];
    int m_state  = 0;
    int m_nb     = 0;
    int m_loaded = 0;
    int m_hold   = 0;
    bit m_err    = 1'b0;
    bit chk_en   = 1'b0;

    function automatic bit m_core_reset();
        return (m_state == 0) || (m_state == 1 && m_hold < HOLD);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_state = 0; m_nb = 0; m_loaded = 0; m_hold = 0; m_err = 1'b0;
        end else if (m_state == 0) begin
            if (in_valid) begin
                if (m_nb < 4 * DEPTH) begin
                    if (m_nb % 4 == 0) m_mem[m_nb / 4] = {24'h0, in_byte};
                    else m_mem[m_nb / 4][8 * (m_nb % 4) +: 8] = in_byte;
                    m_nb++;
                    if (m_nb % 4 == 0) m_loaded++;
                    else if (in_last) begin m_loaded++; m_err = 1'b1; end
                end else begin
                    m_err = 1'b1;
                end
                if (in_last) begin m_state = 1; m_hold = 0; end
            end
        end else if (m_state == 1) begin
            if (core_halted && !m_core_reset()) m_state = 2;
            m_hold++;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            logic [31:0] exp_fd, exp_cs;
            exp_fd = (int'(fetch_addr) < m_loaded) ? m_mem[fetch_addr] : 32'h0000000d;
            exp_cs = 32'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            for (int i = 0; i < m_loaded; i++) exp_cs ^= m_mem[i];
`endif
            chk("in_ready",     32'(in_ready),     32'(m_state == 0));
            chk("core_reset",   32'(core_reset),   32'(m_core_reset()));
            chk("state",        32'(state),        32'(m_state));
            chk("loaded_words", 32'(loaded_words), 32'(m_loaded));
            chk("error",        32'(error),        32'(m_err));
            chk("fetch_data",   fetch_data,        exp_fd);
            chk("checksum",     checksum,          exp_cs);
        end
    end

    logic [31:0] prog [9] = '{32'h00631826, 32'h00001020, 32'h20040005, 32'h00441020,
                              32'h2084ffff, 32'h1480fffd, 32'h00000000, 32'hac020000,
                              32'h0000000d};

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; core_halted = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0; fetch_addr = AB'($urandom_range(0, 15)); tick();
        end
        in_valid = 1'b1; in_byte = b; in_last = last;
        fetch_addr = AB'($urandom_range(0, 15));
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_prog(input bit gaps);
        for (int i = 0; i < 36; i++)
            send_byte(prog[i / 4][8 * (i % 4) +: 8], i == 35, gaps ? $urandom_range(0, 3) : 0);
    endtask

    initial begin
        int k;
        do_reset();
        chk_en = 1'b1;
        chk("rst state",    32'(state), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst core_rst", 32'(core_reset), 32'd1);
        chk("rst loaded",   32'(loaded_words), 32'd0);
        chk("rst error",    32'(error), 32'd0);
        chk("rst checksum", checksum, 32'd0);

        // Gapless program load, hold window, halted handling
        send_prog(1'b0);
        chk("load state", 32'(state), 32'd1);
        chk("load count", 32'(loaded_words), 32'd9);
        k = 0;
        core_halted = 1'b1; in_valid = 1'b1;
        tick(); k++;
        core_halted = 1'b0;
        chk("halt ignored", 32'(state), 32'd1);
        while (core_reset && k < 20) begin tick(); k++; end
        in_valid = 1'b0;
        chk("hold cycles", 32'(k), 32'd4);
        fetch_addr = 8'd9; #1;
        chk("fetch oob", fetch_data, 32'h0000000d);
        fetch_addr = 8'd0; #1;
        chk("fetch 0", fetch_data, 32'h00631826);
        core_halted = 1'b1; tick(); core_halted = 1'b0;
        chk("done state", 32'(state), 32'd2);
        tick();
        chk("done sticky", 32'(state), 32'd2);

        // Partial final word
        do_reset();
        for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6, $urandom_range(0, 2));
        fetch_addr = 8'd1; #1;
        chk("partial word", fetch_data, 32'h00000605);
        fetch_addr = 8'd0; #1;
        chk("partial w0", fetch_data, 32'h04030201);
        chk("partial cnt", 32'(loaded_words), 32'd2);
        chk("partial err", 32'(error), 32'd1);

        // Gappy load gives the same image
        do_reset();
        send_prog(1'b1);
        for (int a = 0; a < 10; a++) begin
            fetch_addr = AB'(a); #1;
            chk("gap image", fetch_data, (a < 9) ? prog[a] : 32'h0000000d);
        end

        // Reset mid-load restarts at address 0
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b0, 0);
        do_reset();
        send_byte(8'hAA, 1'b0, 0); send_byte(8'hBB, 1'b0, 0);
        send_byte(8'hCC, 1'b0, 0); send_byte(8'hDD, 1'b1, 0);
        fetch_addr = 8'd0; #1;
        chk("restart w0", fetch_data, 32'hDDCCBBAA);
        chk("restart cnt", 32'(loaded_words), 32'd1);
        chk("restart err", 32'(error), 32'd0);

        // Overflow: full RAM then one extra byte carrying in_last
        do_reset();
        for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'(i * 7 + 3), 1'b0, 0);
        chk("full no err", 32'(error), 32'd0);
        send_byte(8'h5A, 1'b1, 0);
        chk("ovf err", 32'(error), 32'd1);
        chk("ovf cnt", 32'(loaded_words), 32'(DEPTH));
        chk("ovf state", 32'(state), 32'd1);
        fetch_addr = 8'd255; #1;
        chk("ovf last word", fetch_data,
            {8'(1023 * 7 + 3), 8'(1022 * 7 + 3), 8'(1021 * 7 + 3), 8'(1020 * 7 + 3)});

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
